// File: rtl/mips_fetch_pkg.sv
// Shared fetch-stage types and constants for the MIPS front end.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2
    } fetchState_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;  // MARS text base
    localparam int          WORD_SHIFT       = 2;               // byte offset of a word index
    localparam int          PC_INCR          = 4;               // sequential fetch stride

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/ack bundle between fetch and imem.
// Latency: none (wires only).
// Backpressure: fetch holds ImemReq/ImemAddr until ImemAck is seen.
interface pc_fetch_unit_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  ImemReq;
    logic [DATA_WIDTH-1:0] ImemAddr;
    logic                  ImemAck;
    logic [DATA_WIDTH-1:0] ImemRData;

    modport master (output ImemReq, output ImemAddr, input ImemAck, input ImemRData);
    modport slave  (input ImemReq, input ImemAddr, output ImemAck, output ImemRData);
endinterface

// File: rtl/pc_fetch_unit_next_pc_logic.sv
// Combinational next-PC selection: JR (optional, JR_SUPPORT_EN) > J/JAL > taken branch > PC+4.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller decides when the result is used.
module next_pc_logic
    import mips_fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
`ifdef JR_SUPPORT_EN
    input  logic                  jumpReg,
    input  logic [DATA_WIDTH-1:0] jumpRegTarget,
`endif
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic                  jump,
    input  logic                  branchEq,
    input  logic                  branchNe,
    input  logic                  zero,
    input  logic [DATA_WIDTH-1:0] branchOffset,
    input  logic [25:0]           jumpIndex,
    output logic [DATA_WIDTH-1:0] pcPlus4,
    output logic [DATA_WIDTH-1:0] nextPc
);
    logic                  branchTaken;
    logic [DATA_WIDTH-1:0] branchTarget;
    logic [DATA_WIDTH-1:0] jumpTarget;

    assign pcPlus4      = pc + DATA_WIDTH'(PC_INCR);
    // BEQ and BNE together means either condition is enough to branch.
    assign branchTaken  = (branchEq & zero) | (branchNe & ~zero);
    assign branchTarget = pcPlus4 + (branchOffset << WORD_SHIFT);
    // J-format target keeps the 256 MB region of the delay-slot address.
    assign jumpTarget   = {pcPlus4[DATA_WIDTH-1:28], jumpIndex, {WORD_SHIFT{1'b0}}};

    // Priority mux, lowest priority assigned first so later terms override.
    always_comb begin
        nextPc = pcPlus4;
        if (branchTaken) nextPc = branchTarget;
        if (jump)        nextPc = jumpTarget;
`ifdef JR_SUPPORT_EN
        // Register targets are forced word-aligned rather than trapping.
        if (jumpReg)     nextPc = jumpRegTarget & ~DATA_WIDTH'(3);
`endif
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: holds PC, requests imem words, presents them to decode (JR via JR_SUPPORT_EN).
// Latency: 2 cycles/instruction minimum (REQ with same-cycle ack, then VALID without stall).
// Backpressure: Stall holds the word in VALID; imem backpressure by withholding ImemAck.
module pc_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  reset,
    pc_fetch_unit_if.master       imem,
    input  logic                  Jump,
    input  logic                  BranchEQ,
    input  logic                  BranchNE,
    input  logic                  Zero,
    input  logic [DATA_WIDTH-1:0] BranchOffset,
    input  logic [25:0]           JumpIndex,
`ifdef JR_SUPPORT_EN
    input  logic                  JumpReg,
    input  logic [DATA_WIDTH-1:0] JumpRegTarget,
`endif
    input  logic                  Stall,
    output logic [DATA_WIDTH-1:0] Instruction,
    output logic                  InstrValid,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] PCPlus4,
    output logic [31:0]           InstrCount
);
    fetchState_t           state;
    fetchState_t           nextState;
    logic [DATA_WIDTH-1:0] pcReg;
    logic [DATA_WIDTH-1:0] instrReg;
    logic [DATA_WIDTH-1:0] nextPc;
    logic [31:0]           countReg;
    logic                  capture;
    logic                  consume;

    next_pc_logic #(
        .DATA_WIDTH    (DATA_WIDTH)
    ) uNextPc (
`ifdef JR_SUPPORT_EN
        .jumpReg       (JumpReg),
        .jumpRegTarget (JumpRegTarget),
`endif
        .pc            (pcReg),
        .jump          (Jump),
        .branchEq      (BranchEQ),
        .branchNe      (BranchNE),
        .zero          (Zero),
        .branchOffset  (BranchOffset),
        .jumpIndex     (JumpIndex),
        .pcPlus4       (PCPlus4),
        .nextPc        (nextPc)
    );

    // Next-state decode; acks outside REQ and controls outside consume are ignored.
    always_comb begin
        nextState = state;
        capture   = 1'b0;
        consume   = 1'b0;
        case (state)
            IDLE:    nextState = REQ;
            REQ: begin
                if (imem.ImemAck) begin
                    capture   = 1'b1;
                    nextState = VALID;
                end
            end
            VALID: begin
                if (!Stall) begin
                    consume   = 1'b1;
                    nextState = REQ;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // PC, held instruction and retired-instruction counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcReg    <= RESET_PC;
            instrReg <= '0;
            countReg <= '0;
        end else begin
            if (capture) instrReg <= imem.ImemRData;
            if (consume) begin
                pcReg    <= nextPc;
                countReg <= countReg + 32'd1;
            end
        end
    end

    assign imem.ImemReq  = (state == REQ);
    assign imem.ImemAddr = pcReg;
    assign Instruction   = instrReg;
    assign InstrValid    = (state == VALID);
    assign PC            = pcReg;
    assign InstrCount    = countReg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed plus randomized bench for pc_fetch_unit against an arithmetic next-PC model.
// Latency: n/a.
// Backpressure: bench drives Stall and delayed ImemAck.
module tb_pc_fetch_unit;
    import mips_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        Jump, BranchEQ, BranchNE, Zero, Stall;
    logic [31:0] BranchOffset;
    logic [25:0] JumpIndex;
    logic [31:0] Instruction, PC, PCPlus4, InstrCount;
    logic        InstrValid;
`ifdef JR_SUPPORT_EN
    logic        JumpReg;
    logic [31:0] JumpRegTarget;
`endif

    pc_fetch_unit_if #(.DATA_WIDTH(32)) imem ();

    pc_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .imem          (imem),
        .Jump          (Jump),
        .BranchEQ      (BranchEQ),
        .BranchNE      (BranchNE),
        .Zero          (Zero),
        .BranchOffset  (BranchOffset),
        .JumpIndex     (JumpIndex),
`ifdef JR_SUPPORT_EN
        .JumpReg       (JumpReg),
        .JumpRegTarget (JumpRegTarget),
`endif
        .Stall         (Stall),
        .Instruction   (Instruction),
        .InstrValid    (InstrValid),
        .PC            (PC),
        .PCPlus4       (PCPlus4),
        .InstrCount    (InstrCount)
    );

    always #5 clk = ~clk;

    int          passed = 0;
    int          total  = 0;
    logic [31:0] expPc;
    logic [31:0] expCount;
    logic [31:0] expInstr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference next-PC computed from the ISA rules with plain arithmetic.
    function automatic logic [31:0] refNext(input logic [31:0] pc, input logic j, input logic beq,
                                            input logic bne, input logic z, input logic [31:0] off,
                                            input logic [25:0] idx);
        logic [31:0] seq;
        seq = pc + 32'd4;
        if (j)                              return (seq & 32'hF000_0000) + ({6'd0, idx} * 32'd4);
        if ((beq && z) || (bne && !z))      return seq + off * 32'd4;
        return seq;
    endfunction

    task automatic randCtrl();
        Jump         = 1'($urandom_range(0, 1));
        BranchEQ     = 1'($urandom_range(0, 1));
        BranchNE     = 1'($urandom_range(0, 1));
        Zero         = 1'($urandom_range(0, 1));
        BranchOffset = $urandom;
        JumpIndex    = 26'($urandom);
    endtask

    task automatic checkReset(input string tag);
        check({tag, "_req"},   32'(imem.ImemReq), 32'd0);
        check({tag, "_valid"}, 32'(InstrValid),   32'd0);
        check({tag, "_pc"},    PC,                32'h0040_0000);
        check({tag, "_instr"}, Instruction,       32'd0);
        check({tag, "_count"}, InstrCount,        32'd0);
    endtask

    // Entered with the DUT in REQ; ack after `delay` wait cycles.
    task automatic fetch(input int delay, input logic [31:0] word);
        for (int i = 0; i < delay; i++) begin
            check("req_held",  32'(imem.ImemReq), 32'd1);
            check("addr_held", imem.ImemAddr,     expPc);
            check("no_valid",  32'(InstrValid),   32'd0);
            randCtrl();
            imem.ImemRData = $urandom;
            step();
        end
        check("req",  32'(imem.ImemReq), 32'd1);
        check("addr", imem.ImemAddr,     expPc);
        imem.ImemAck   = 1'b1;
        imem.ImemRData = word;
        step();
        imem.ImemAck = 1'b0;
        expInstr     = word;
        check("valid",   32'(InstrValid), 32'd1);
        check("instr",   Instruction,     expInstr);
        check("pc_v",    PC,              expPc);
        check("pcplus4", PCPlus4,         expPc + 32'd4);
        check("count_v", InstrCount,      expCount);
    endtask

    // Entered with the DUT in VALID; stall then consume with given controls.
    task automatic consume(input int stalls, input logic j, input logic beq, input logic bne,
                           input logic z, input logic [31:0] off, input logic [25:0] idx);
        for (int i = 0; i < stalls; i++) begin
            Stall = 1'b1;
            randCtrl();
            imem.ImemAck   = 1'b1;
            imem.ImemRData = ~expInstr;
            step();
            imem.ImemAck = 1'b0;
            check("stall_valid", 32'(InstrValid), 32'd1);
            check("stall_instr", Instruction,     expInstr);
            check("stall_pc",    PC,              expPc);
            check("stall_count", InstrCount,      expCount);
        end
        Stall = 1'b0;
        Jump = j; BranchEQ = beq; BranchNE = bne; Zero = z;
        BranchOffset = off; JumpIndex = idx;
        step();
        expPc    = refNext(expPc, j, beq, bne, z, off, idx);
        expCount = expCount + 32'd1;
        check("cons_valid", 32'(InstrValid), 32'd0);
        check("cons_req",   32'(imem.ImemReq), 32'd1);
        check("cons_pc",    PC,              expPc);
        check("cons_addr",  imem.ImemAddr,   expPc);
        check("cons_count", InstrCount,      expCount);
        randCtrl();
        Stall = 1'($urandom_range(0, 1));
    endtask

    initial begin
        reset = 1'b0;
        Jump = 0; BranchEQ = 0; BranchNE = 0; Zero = 0; Stall = 0;
        BranchOffset = '0; JumpIndex = '0;
`ifdef JR_SUPPORT_EN
        JumpReg = 1'b0; JumpRegTarget = '0;
`endif
        imem.ImemAck = 1'b0; imem.ImemRData = '0;
        expPc = 32'h0040_0000; expCount = 0; expInstr = 0;

        step(); step();
        checkReset("reset");
        reset = 1'b1;
        check("idle_req", 32'(imem.ImemReq), 32'd0);
        step();

        // Same-cycle ack, then unstalled consume.
        fetch(0, 32'h2008_0005);
        consume(0, 0, 0, 0, 0, 32'd0, 26'd0);
        check("t1_pc", PC, 32'h0040_0004);

        // Delayed ack.
        fetch(3, 32'h1234_5678);
        consume(0, 0, 0, 0, 0, 32'd0, 26'd0);

        // Long stall with stray acks in VALID.
        fetch(1, 32'hCAFE_F00D);
        consume(5, 0, 0, 0, 0, 32'd0, 26'd0);
        fetch(0, $urandom);
        consume(0, 0, 0, 0, 0, 32'd0, 26'd0);
        check("at_10", PC, 32'h0040_0010);

        // BEQ taken backward, then BEQ not taken.
        fetch(0, $urandom);
        consume(0, 0, 1, 0, 1, 32'hFFFF_FFFE, 26'd0);
        check("beq_taken", PC, 32'h0040_000C);
        fetch(0, $urandom);
        consume(0, 0, 0, 0, 0, 32'd0, 26'd0);
        fetch(0, $urandom);
        consume(0, 0, 1, 0, 0, 32'hFFFF_FFFE, 26'd0);
        check("beq_not", PC, 32'h0040_0014);
        fetch(0, $urandom);
        consume(0, 0, 0, 1, 0, 32'd2, 26'd0);
        check("bne_taken", PC, 32'h0040_0020);

        // Jump beats a taken BNE.
        fetch(0, $urandom);
        check("pcplus4_20", PCPlus4, 32'h0040_0024);
        consume(0, 1, 0, 1, 0, 32'd7, 26'h010_0008);
        check("jump_wins", PC, 32'h0040_0020);

        // Randomized instruction stream.
        for (int n = 0; n < 40; n++) begin
            logic j, beq, bne, z;
            j   = ($urandom_range(0, 3) == 0);
            beq = 1'($urandom_range(0, 1));
            bne = 1'($urandom_range(0, 1));
            z   = 1'($urandom_range(0, 1));
            fetch($urandom_range(0, 3), $urandom);
            consume($urandom_range(0, 2), j, beq, bne, z, $urandom, 26'($urandom));
        end

        // Reset while waiting for an ack, with a late ack during reset.
        imem.ImemAck = 1'b0;
        step();
        reset = 1'b0;
        #1;
        checkReset("arst");
        imem.ImemAck   = 1'b1;
        imem.ImemRData = 32'hDEAD_BEEF;
        step(); step();
        checkReset("arst_ack");
        reset        = 1'b1;
        imem.ImemAck = 1'b0;
        step();
        expPc = 32'h0040_0000; expCount = 0;
        check("restart_addr", imem.ImemAddr, 32'h0040_0000);
        fetch(0, 32'h0BAD_CAFE);
        consume(0, 0, 0, 0, 0, 32'd0, 26'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Fetch stage directly upstream of the decode/control stage of the MIPS core. It holds the program counter and issues requests to instruction memory over a req/ack handshake. It presents each fetched word to decode and, once decode consumes it, computes the next PC from the control outputs (Jump, BranchEQ, BranchNE) and the ALU Zero flag. It also supplies PC+4 for JAL linking.

Parameters:
DATA_WIDTH, 32, width of PC, instruction and offset buses
RESET_PC, 32'h0040_0000, PC value loaded on reset (MARS text base)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
Jump  in  1  from control; J/JAL taken
BranchEQ  in  1  from control; BEQ instruction
BranchNE  in  1  from control; BNE instruction
Zero  in  1  ALU equality result for current instruction
BranchOffset  in  DATA_WIDTH  sign-extended 16-bit immediate
JumpIndex  in  26  instr[25:0] of current instruction
Stall  in  1  decode cannot accept instruction this cycle
ImemAck  in  1  instruction memory data valid
ImemRData  in  DATA_WIDTH  instruction memory read data
ImemReq  out  1  fetch request
ImemAddr  out  DATA_WIDTH  fetch address (= PC)
Instruction  out  DATA_WIDTH  held instruction word
InstrValid  out  1  Instruction is valid for decode
PC  out  DATA_WIDTH  address of held instruction
PCPlus4  out  DATA_WIDTH  PC+4, JAL link value
InstrCount  out  32  consumed-instruction counter

Behaviour:
- Reset asserted (async, any cycle, including mid-handshake): state=IDLE, PC=RESET_PC, Instruction=0, InstrValid=0, ImemReq=0, InstrCount=0. Any ack arriving during reset is ignored.
- IDLE: one cycle after reset release, go to REQ.
- REQ: ImemReq=1 and ImemAddr=PC, both held stable until ack.
  - ImemAck=1 in the same cycle: latch ImemRData into Instruction, InstrValid=1 next cycle, go to VALID.
  - No ack: stay in REQ.
  - Ack while not in REQ: ignored.
- VALID: InstrValid=1 and Instruction held.
  - Stall=1: hold everything. PC, Instruction and InstrCount do not change.
  - Stall=0 (consume): InstrCount+=1 (wraps 2^32-1 -> 0), PC<=NextPC, InstrValid<=0, go to REQ.
- Minimum latency is 2 cycles per instruction (REQ with same-cycle ack, then VALID with no stall).
- NextPC, sampled only at consume. Priority, highest first:
  - Jump=1: {PCPlus4[31:28], JumpIndex, 2'b00}
  - (BranchEQ & Zero) | (BranchNE & ~Zero): PCPlus4 + (BranchOffset << 2), modulo 2^32
  - otherwise: PCPlus4
- Jump together with any branch: Jump wins. BranchEQ and BranchNE both high: either condition met causes the branch.
- Control inputs are ignored outside the VALID consume cycle.
- PC[1:0] is always 00. Targets are formed so that this holds; RESET_PC must be word-aligned.
- PCPlus4 = PC+4 combinationally; 32'hFFFF_FFFC wraps to 0.

Optional Feature:
JR_SUPPORT_EN
- Defined: adds ports JumpReg (in, 1) and JumpRegTarget (in, DATA_WIDTH).
  - JumpReg has highest priority.
  - NextPC = {JumpRegTarget[31:2], 2'b00}; the low bits are silently cleared.
- Undefined: those ports are absent and the priority is as listed in Behaviour.

Decomposition:
- Package mips_fetch_pkg:
  - fetch-state enum (IDLE, REQ, VALID)
  - RESET_PC default
  - word-shift constant 2
  - PC increment constant 4
- Sub-module next_pc_logic: purely combinational NextPC mux and adders. The top level keeps the FSM, PC/instruction registers and counter.

Test Plan:
1. Reset release, ack in the same cycle as the first req -> ImemAddr=0x00400000, then InstrValid=1 with the captured word. Stall=0 gives PC=0x00400004 and InstrCount=1.
2. Ack delayed 3 cycles -> ImemReq and ImemAddr stable for 4 cycles, InstrValid stays 0, then one valid instruction.
3. PC=0x00400010, BranchEQ=1, Zero=1, BranchOffset=0xFFFFFFFE -> next PC 0x0040000C. Same with Zero=0 -> 0x00400014.
4. PC=0x00400020, Jump=1, BranchNE=1, Zero=0, JumpIndex=0x0100008 -> next PC 0x00400020 (Jump wins). PCPlus4 observed as 0x00400024.
5. Stall=1 for 5 cycles in VALID -> Instruction, PC and InstrCount unchanged. Release gives exactly one increment.
6. Reset asserted while in REQ awaiting ack, late ack during reset -> outputs immediately at reset values. After release, the fetch restarts at 0x00400000.
